// File: rtl/elevator_pkg.sv
// Shared types and helpers for the elevator controller: state encoding,
// floor-index width and one-hot decode.
package elevator_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MOVE_UP   = 2'd1,
        MOVE_DOWN = 2'd2,
        DOOR_OPEN = 2'd3
    } state_t;

    localparam int MAX_FLOORS = 64;

    function automatic int floor_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Callers truncate the result to their own floor count.
    function automatic logic [MAX_FLOORS-1:0] onehot(input logic [31:0] idx);
        return MAX_FLOORS'(1) << idx;
    endfunction

endpackage

// File: rtl/elevator_control_request_scan.sv
// Combinational request scan: flags any pending request above, below or at a
// floor index. No latency, no flow control.
module request_scan
    import elevator_pkg::*;
#(
    parameter int W  = 8,
    parameter int FW = 3
) (
    input  logic [W-1:0]  in_i,
    input  logic [W-1:0]  up_i,
    input  logic [W-1:0]  down_i,
    input  logic [FW-1:0] floor_i,
    output logic          above_o,
    output logic          below_o,
    output logic          here_o
);

    logic [W-1:0] req;

    always_comb begin
        req     = in_i | up_i | down_i;
        above_o = 1'b0;
        below_o = 1'b0;
        here_o  = 1'b0;
        for (int i = 0; i < W; i++) begin
            if (req[i]) begin
                if (i > int'(floor_i)) above_o = 1'b1;
                if (i < int'(floor_i)) below_o = 1'b1;
                if (i == int'(floor_i)) here_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/elevator_control.sv
// SCAN elevator motion/door controller; all outputs registered, decisions take
// one cycle. Optional door hold input under ELEVATOR_DOOR_HOLD_EN.
module elevator_control
    import elevator_pkg::*;
#(
    parameter int  BUTTONS_WIDTH = 8,
    parameter int  FLOOR_TICKS   = 16,
    parameter int  DOOR_TICKS    = 8,
    localparam int FLOOR_W       = floor_w(BUTTONS_WIDTH)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [BUTTONS_WIDTH-1:0] active_in_levels,
    input  logic [BUTTONS_WIDTH-1:0] active_out_up_levels,
    input  logic [BUTTONS_WIDTH-1:0] active_out_down_levels,
`ifdef ELEVATOR_DOOR_HOLD_EN
    input  logic                     door_hold,
`endif
    output logic [BUTTONS_WIDTH-1:0] inactivate_in_levels,
    output logic [BUTTONS_WIDTH-1:0] inactivate_out_up_levels,
    output logic [BUTTONS_WIDTH-1:0] inactivate_out_down_levels,
    output logic [FLOOR_W-1:0]       current_floor,
    output logic                     dir_up,
    output logic                     motor_up,
    output logic                     motor_down,
    output logic                     door_open
);

    localparam int TMAX = (FLOOR_TICKS > DOOR_TICKS) ? FLOOR_TICKS : DOOR_TICKS;
    localparam int TW   = $clog2(TMAX + 1);
    localparam logic [TW-1:0]      FLOOR_RLD = TW'(FLOOR_TICKS - 1);
    localparam logic [TW-1:0]      DOOR_RLD  = TW'(DOOR_TICKS - 1);
    localparam logic [FLOOR_W-1:0] TOP_FLOOR = FLOOR_W'(BUTTONS_WIDTH - 1);

    state_t                   state_q;
    logic [FLOOR_W-1:0]       floor_q, floor_step_d;
    logic                     dir_up_q;
    logic [TW-1:0]            move_tmr_q, door_tmr_q;
    logic                     motor_up_q, motor_down_q, door_open_q;
    logic [BUTTONS_WIDTH-1:0] clr_in_q, clr_up_q, clr_dn_q;

    logic above_c, below_c, here_c, above_n, below_n, here_n;
    logic [BUTTONS_WIDTH-1:0] oh_cur, oh_nxt, ent_oh;
    logic ent_above, ent_below, ent_ahead;
    logic hit_in, hit_up, hit_dn, stop_up, stop_dn, stop_d, tick_done;
    logic go_up, go_dn, enter_door, hold_w;

`ifdef ELEVATOR_DOOR_HOLD_EN
    assign hold_w = door_hold;
`else
    assign hold_w = 1'b0;
`endif

    // Floor the car reaches when the travel timer expires, clamped to the shaft.
    always_comb begin
        floor_step_d = floor_q;
        if (state_q == MOVE_DOWN) begin
            if (floor_q != '0) floor_step_d = floor_q - 1'b1;
        end else if (floor_q != TOP_FLOOR) begin
            floor_step_d = floor_q + 1'b1;
        end
    end

    request_scan #(.W(BUTTONS_WIDTH), .FW(FLOOR_W)) u_scan_cur (
        .in_i(active_in_levels), .up_i(active_out_up_levels), .down_i(active_out_down_levels),
        .floor_i(floor_q), .above_o(above_c), .below_o(below_c), .here_o(here_c)
    );

    request_scan #(.W(BUTTONS_WIDTH), .FW(FLOOR_W)) u_scan_nxt (
        .in_i(active_in_levels), .up_i(active_out_up_levels), .down_i(active_out_down_levels),
        .floor_i(floor_step_d), .above_o(above_n), .below_o(below_n), .here_o(here_n)
    );

    assign oh_cur = BUTTONS_WIDTH'(onehot(32'(floor_q)));
    assign oh_nxt = BUTTONS_WIDTH'(onehot(32'(floor_step_d)));

    assign hit_in    = |(active_in_levels & oh_nxt);
    assign hit_up    = |(active_out_up_levels & oh_nxt);
    assign hit_dn    = |(active_out_down_levels & oh_nxt);
    // A call for the opposite direction only stops the car when it is the last stop ahead.
    assign stop_up   = (here_n & (hit_in | hit_up | ~above_n)) | (floor_step_d == TOP_FLOOR);
    assign stop_dn   = (here_n & (hit_in | hit_dn | ~below_n)) | (floor_step_d == '0);
    assign stop_d    = (state_q == MOVE_UP) ? stop_up : stop_dn;
    assign tick_done = (move_tmr_q == '0);

    assign go_up = dir_up_q ? above_c : (above_c & ~below_c);
    assign go_dn = dir_up_q ? (below_c & ~above_c) : below_c;

    assign ent_above = (state_q == IDLE) ? above_c : above_n;
    assign ent_below = (state_q == IDLE) ? below_c : below_n;
    assign ent_oh    = (state_q == IDLE) ? oh_cur : oh_nxt;
    assign ent_ahead = dir_up_q ? ent_above : ent_below;

    assign enter_door = ((state_q == IDLE) && here_c) ||
                        (((state_q == MOVE_UP) || (state_q == MOVE_DOWN)) && tick_done && stop_d);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            floor_q      <= '0;
            dir_up_q     <= 1'b1;
            move_tmr_q   <= '0;
            door_tmr_q   <= '0;
            motor_up_q   <= 1'b0;
            motor_down_q <= 1'b0;
            door_open_q  <= 1'b0;
            clr_in_q     <= '0;
            clr_up_q     <= '0;
            clr_dn_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!here_c) begin
                        if (go_up) begin
                            state_q    <= MOVE_UP;
                            motor_up_q <= 1'b1;
                            dir_up_q   <= 1'b1;
                            move_tmr_q <= FLOOR_RLD;
                        end else if (go_dn) begin
                            state_q      <= MOVE_DOWN;
                            motor_down_q <= 1'b1;
                            dir_up_q     <= 1'b0;
                            move_tmr_q   <= FLOOR_RLD;
                        end
                    end
                end
                MOVE_UP, MOVE_DOWN: begin
                    if (tick_done) begin
                        floor_q    <= floor_step_d;
                        move_tmr_q <= FLOOR_RLD;
                    end else begin
                        move_tmr_q <= move_tmr_q - 1'b1;
                    end
                end
                DOOR_OPEN: begin
                    if (hold_w) begin
                        door_tmr_q <= DOOR_RLD;
                    end else if (door_tmr_q == '0) begin
                        state_q     <= IDLE;
                        door_open_q <= 1'b0;
                        clr_in_q    <= '0;
                        clr_up_q    <= '0;
                        clr_dn_q    <= '0;
                    end else begin
                        door_tmr_q <= door_tmr_q - 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase

            // Clears follow the arrival direction; the flip applies to the next departure.
            if (enter_door) begin
                state_q      <= DOOR_OPEN;
                motor_up_q   <= 1'b0;
                motor_down_q <= 1'b0;
                door_open_q  <= 1'b1;
                door_tmr_q   <= DOOR_RLD;
                clr_in_q     <= ent_oh;
                clr_up_q     <= (dir_up_q || !ent_ahead) ? ent_oh : '0;
                clr_dn_q     <= (!dir_up_q || !ent_ahead) ? ent_oh : '0;
                dir_up_q     <= ent_ahead ? dir_up_q : ~dir_up_q;
            end
        end
    end

    assign inactivate_in_levels       = clr_in_q;
    assign inactivate_out_up_levels   = clr_up_q;
    assign inactivate_out_down_levels = clr_dn_q;
    assign current_floor              = floor_q;
    assign dir_up                     = dir_up_q;
    assign motor_up                   = motor_up_q;
    assign motor_down                 = motor_down_q;
    assign door_open                  = door_open_q;

endmodule

// File: tb/tb_elevator_control.sv
// Directed bench for elevator_control (8 floors, 4-cycle travel, 3-cycle dwell)
// with a small latch-and-clear model of the upstream button block.
module tb_elevator_control;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] lat_in = '0, lat_up = '0, lat_dn = '0;
    logic [7:0] act_in, act_up, act_dn;
    logic [7:0] inact_in, inact_up, inact_dn;
    logic [2:0] cur_floor;
    logic       dir_up, motor_up, motor_down, door_open;
`ifdef ELEVATOR_DOOR_HOLD_EN
    logic       door_hold = 1'b0;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    assign act_in = lat_in & ~inact_in;
    assign act_up = lat_up & ~inact_up;
    assign act_dn = lat_dn & ~inact_dn;

    elevator_control #(.BUTTONS_WIDTH(8), .FLOOR_TICKS(4), .DOOR_TICKS(3)) dut (
        .clk                        (clk),
        .reset                      (reset),
        .active_in_levels           (act_in),
        .active_out_up_levels       (act_up),
        .active_out_down_levels     (act_dn),
`ifdef ELEVATOR_DOOR_HOLD_EN
        .door_hold                  (door_hold),
`endif
        .inactivate_in_levels       (inact_in),
        .inactivate_out_up_levels   (inact_up),
        .inactivate_out_down_levels (inact_dn),
        .current_floor              (cur_floor),
        .dir_up                     (dir_up),
        .motor_up                   (motor_up),
        .motor_down                 (motor_down),
        .door_open                  (door_open)
    );

    // One clock; the button latches drop whatever was cleared during the cycle.
    task automatic tick;
        logic [7:0] ci, cu, cd;
        ci = inact_in; cu = inact_up; cd = inact_dn;
        @(posedge clk);
        #1;
        lat_in = lat_in & ~ci;
        lat_up = lat_up & ~cu;
        lat_dn = lat_dn & ~cd;
    endtask

    task automatic test_reset;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (cur_floor !== 3'd0) $display("FAIL reset_floor: got %0d expected 0", cur_floor);
        else n_pass++;
        n_checks++;
        if (dir_up !== 1'b1) $display("FAIL reset_dir: got %b expected 1", dir_up);
        else n_pass++;
        n_checks++;
        if ({motor_up, motor_down, door_open} !== 3'b000)
            $display("FAIL reset_motor_door: got %b expected 000", {motor_up, motor_down, door_open});
        else n_pass++;
        n_checks++;
        if ({inact_in, inact_up, inact_dn} !== 24'h0)
            $display("FAIL reset_inact: got %h expected 000000", {inact_in, inact_up, inact_dn});
        else n_pass++;
        reset = 1'b0;
        repeat (3) tick();
        n_checks++;
        if ({motor_up, motor_down, door_open, cur_floor} !== 6'b0)
            $display("FAIL idle_no_req: got %b expected 000000", {motor_up, motor_down, door_open, cur_floor});
        else n_pass++;
    endtask

    task automatic test_request_here;
        int door_cnt, motor_cnt;
        lat_up[0] = 1'b1;
        tick();
        n_checks++;
        if (door_open !== 1'b1) $display("FAIL here_door: got %b expected 1", door_open);
        else n_pass++;
        n_checks++;
        if (inact_up !== 8'h01) $display("FAIL here_clr_up: got %h expected 01", inact_up);
        else n_pass++;
        n_checks++;
        if (inact_in !== 8'h01) $display("FAIL here_clr_in: got %h expected 01", inact_in);
        else n_pass++;
        door_cnt = 1; motor_cnt = 0;
        repeat (5) begin
            tick();
            if (door_open) door_cnt++;
            if (motor_up || motor_down) motor_cnt++;
        end
        n_checks++;
        if (door_cnt != 3) $display("FAIL here_dwell: got %0d expected 3", door_cnt);
        else n_pass++;
        n_checks++;
        if (motor_cnt != 0) $display("FAIL here_motor: got %0d expected 0", motor_cnt);
        else n_pass++;
    endtask

    task automatic test_single_request;
        int up_cnt, door_cnt, clr_ok;
        logic [2:0] door_floor;
        door_floor = '0;
        lat_in[2] = 1'b1;
        tick();
        n_checks++;
        if (motor_up !== 1'b1) $display("FAIL single_start: got %b expected 1", motor_up);
        else n_pass++;
        up_cnt = 1; door_cnt = 0; clr_ok = 0;
        repeat (13) begin
            tick();
            if (motor_up) up_cnt++;
            if (door_open) begin
                if (door_cnt == 0) door_floor = cur_floor;
                door_cnt++;
                if (inact_in == 8'b0000_0100) clr_ok++;
            end
        end
        n_checks++;
        if (up_cnt != 8) $display("FAIL single_travel: got %0d expected 8", up_cnt);
        else n_pass++;
        n_checks++;
        if (door_cnt != 3) $display("FAIL single_dwell: got %0d expected 3", door_cnt);
        else n_pass++;
        n_checks++;
        if (door_floor !== 3'd2) $display("FAIL single_floor: got %0d expected 2", door_floor);
        else n_pass++;
        n_checks++;
        if (clr_ok != 3) $display("FAIL single_clr_in: got %0d cycles expected 3", clr_ok);
        else n_pass++;
        n_checks++;
        if ({motor_up, motor_down, door_open, inact_in} !== 11'b0)
            $display("FAIL single_idle: got %b expected 0", {motor_up, motor_down, door_open, inact_in});
        else n_pass++;
    endtask

    task automatic go_floor(input int f);
        logic seen;
        logic [2:0] fl;
        seen = 1'b0; fl = '0;
        lat_in[f] = 1'b1;
        for (int k = 0; k < 200 && !(seen && !door_open); k++) begin
            tick();
            if (door_open && !seen) begin
                seen = 1'b1;
                fl = cur_floor;
            end
        end
        n_checks++;
        if (!seen || fl !== 3'(f)) $display("FAIL go_floor: got seen=%b floor=%0d expected floor %0d", seen, fl, f);
        else n_pass++;
        tick();
    endtask

    task automatic record_two_stops(output int nstops, output logic [2:0] fl0, output logic [2:0] fl1,
                                    output logic [7:0] up0, output logic [7:0] dn1);
        logic prev;
        prev = 1'b0; nstops = 0; fl0 = '0; fl1 = '0; up0 = '0; dn1 = '0;
        for (int k = 0; k < 300 && !(nstops == 2 && !door_open); k++) begin
            tick();
            if (door_open && !prev) begin
                if (nstops == 0) begin fl0 = cur_floor; up0 = inact_up; end
                else if (nstops == 1) begin fl1 = cur_floor; dn1 = inact_dn; end
                nstops++;
            end
            prev = door_open;
        end
    endtask

    task automatic test_hall_direction;
        int n;
        logic [2:0] f0, f1;
        logic [7:0] u0, d1;
        go_floor(0);
        lat_dn[3] = 1'b1;
        lat_up[5] = 1'b1;
        record_two_stops(n, f0, f1, u0, d1);
        n_checks++;
        if (n != 2) $display("FAIL hall_stop_count: got %0d expected 2", n);
        else n_pass++;
        n_checks++;
        if (f0 !== 3'd5) $display("FAIL hall_first_stop: got %0d expected 5", f0);
        else n_pass++;
        n_checks++;
        if (u0 !== 8'b0010_0000) $display("FAIL hall_clr_up5: got %h expected 20", u0);
        else n_pass++;
        n_checks++;
        if (f1 !== 3'd3) $display("FAIL hall_second_stop: got %0d expected 3", f1);
        else n_pass++;
        n_checks++;
        if (d1 !== 8'b0000_1000) $display("FAIL hall_clr_down3: got %h expected 08", d1);
        else n_pass++;
        tick();
    endtask

    task automatic test_simultaneous;
        int n;
        logic [2:0] f0, f1;
        logic [7:0] u0, d1;
        go_floor(4);
        n_checks++;
        if (dir_up !== 1'b0) $display("FAIL simul_dir_down: got %b expected 0", dir_up);
        else n_pass++;
        lat_in[6] = 1'b1;
        lat_in[1] = 1'b1;
        record_two_stops(n, f0, f1, u0, d1);
        n_checks++;
        if (n != 2 || f0 !== 3'd1) $display("FAIL simul_first: got n=%0d floor=%0d expected floor 1", n, f0);
        else n_pass++;
        n_checks++;
        if (f1 !== 3'd6) $display("FAIL simul_second: got %0d expected 6", f1);
        else n_pass++;
        tick();
    endtask

    task automatic test_reset_mid_move;
        logic reached;
        reached = 1'b0;
        go_floor(0);
        lat_in[5] = 1'b1;
        for (int k = 0; k < 100 && !reached; k++) begin
            tick();
            if (cur_floor == 3'd3 && motor_up) reached = 1'b1;
        end
        n_checks++;
        if (!reached) $display("FAIL rst_reach_f3: got floor %0d expected floor 3 moving up", cur_floor);
        else n_pass++;
        reset = 1'b1;
        #1;
        n_checks++;
        if (cur_floor !== 3'd0) $display("FAIL rst_mid_floor: got %0d expected 0", cur_floor);
        else n_pass++;
        n_checks++;
        if ({motor_up, motor_down, door_open, dir_up} !== 4'b0001)
            $display("FAIL rst_mid_outs: got %b expected 0001", {motor_up, motor_down, door_open, dir_up});
        else n_pass++;
        n_checks++;
        if ({inact_in, inact_up, inact_dn} !== 24'h0)
            $display("FAIL rst_mid_inact: got %h expected 000000", {inact_in, inact_up, inact_dn});
        else n_pass++;
        lat_in = '0; lat_up = '0; lat_dn = '0;
        repeat (2) tick();
        reset = 1'b0;
        repeat (2) tick();
        n_checks++;
        if ({motor_up, motor_down, door_open, cur_floor} !== 6'b0)
            $display("FAIL rst_after_idle: got %b expected 000000", {motor_up, motor_down, door_open, cur_floor});
        else n_pass++;
    endtask

`ifdef ELEVATOR_DOOR_HOLD_EN
    task automatic test_door_hold;
        int door_cnt;
        door_cnt = 0;
        door_hold = 1'b1;
        lat_in[0] = 1'b1;
        tick();
        if (door_open) door_cnt++;
        repeat (10) begin
            tick();
            if (door_open) door_cnt++;
        end
        door_hold = 1'b0;
        repeat (6) begin
            tick();
            if (door_open) door_cnt++;
        end
        n_checks++;
        if (door_cnt != 13) $display("FAIL door_hold_dwell: got %0d expected 13", door_cnt);
        else n_pass++;
        n_checks++;
        if (door_open !== 1'b0) $display("FAIL door_hold_closed: got %b expected 0", door_open);
        else n_pass++;
    endtask
`endif

    initial begin
        test_reset();
        test_request_here();
        repeat (2) tick();
        test_single_request();
        test_hall_direction();
        test_simultaneous();
        test_reset_mid_move();
`ifdef ELEVATOR_DOOR_HOLD_EN
        test_door_hold();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d/%0d", n_pass, n_checks);
        $fatal(1);
    end

endmodule

// File: doc/elevator_control.md
# elevator_control

Elevator motion and door controller that sits directly downstream of `buttons`. It consumes the latched request vectors `active_*_levels` and runs a direction-preserving (SCAN) service policy. It drives motor and door outputs and returns `inactivate_*_levels` to `buttons` to clear requests that have been served. It holds the authoritative current-floor register for the car.

## Interface
- `BUTTONS_WIDTH`, 8: number of floors; must match `buttons`.
- `FLOOR_TICKS`, 16: clock cycles to travel one floor; must be ≥1.
- `DOOR_TICKS`, 8: clock cycles the door stays open per stop; must be ≥1.
- `clk` input 1: system clock, rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `active_in_levels` input BUTTONS_WIDTH: car-panel requests, one bit per floor.
- `active_out_up_levels` input BUTTONS_WIDTH: hall up-requests.
- `active_out_down_levels` input BUTTONS_WIDTH: hall down-requests.
- `inactivate_in_levels` output BUTTONS_WIDTH: clear strobe for car requests, to `buttons`.
- `inactivate_out_up_levels` output BUTTONS_WIDTH: clear strobe for hall up-requests.
- `inactivate_out_down_levels` output BUTTONS_WIDTH: clear strobe for hall down-requests.
- `current_floor` output FLOOR_W: car position, where FLOOR_W = max(1, clog2(BUTTONS_WIDTH)).
- `dir_up` output 1: service direction; 1 = up, 0 = down.
- `motor_up` output 1: car moving up.
- `motor_down` output 1: car moving down.
- `door_open` output 1: door open.
- `door_hold` input 1: door hold request. Present only with `ELEVATOR_DOOR_HOLD_EN`.

## Operation
- **States:** IDLE, MOVE_UP, MOVE_DOWN, DOOR_OPEN.
- **Reset values:**
  - state = IDLE, `current_floor` = 0, `dir_up` = 1.
  - All motor, door and inactivate outputs = 0; both timers = 0.
  - Reset asserted mid-move or with the door open aborts immediately to these values.
- **Derived terms:** computed each cycle from the inputs.
  - `req = in | up | down`.
  - `above` = any `req` bit at a floor > cur.
  - `below` = any `req` bit at a floor < cur.
  - `here` = `req[cur]`.
- **IDLE:**
  - If `here`, go to DOOR_OPEN.
  - Else if `dir_up`: go to MOVE_UP if `above`, else MOVE_DOWN if `below`.
  - Else (down): go to MOVE_DOWN if `below`, else MOVE_UP if `above`.
  - Set `dir_up` to match the direction chosen.
  - With no requests, stay in IDLE.
- **MOVE_UP / MOVE_DOWN:**
  - Travel timer loads FLOOR_TICKS-1 on entry and counts down.
  - At 0: `current_floor` steps ±1 and the stop test is evaluated on the new floor f.
- **Stop at f (moving up)** if any of:
  - `in[f]`;
  - `up[f]`;
  - `down[f]` and no requests above f;
  - f = BUTTONS_WIDTH-1.
- **Stop at f (moving down):** symmetric — `in[f]`, `down[f]`, `up[f]` with nothing below f, or f = 0.
- **On stop:** go to DOOR_OPEN. Otherwise reload the timer and continue.
- **Direction reversal:** when entering DOOR_OPEN with no requests ahead (other than at f), `dir_up` flips.
- **DOOR_OPEN:**
  - `door_open` = 1; door timer loads DOOR_TICKS-1 on entry.
  - Asserted every cycle in this state:
    - `inactivate_in_levels` = one-hot(cur);
    - the hall-call clear matching `dir_up` = one-hot(cur);
    - the opposite hall-call clear = one-hot(cur) only if there are no requests ahead.
  - Presses at the current floor during this state are therefore absorbed. Because `buttons` gives a held button priority over clear, a held button stays active.
  - On timer expiry, go to IDLE.
- **Output rules:**
  - `motor_up` = 1 exactly in MOVE_UP; `motor_down` = 1 exactly in MOVE_DOWN; never both.
  - Inactivate outputs are 0 outside DOOR_OPEN.
- **Boundaries:**
  - The car never steps below 0 or above BUTTONS_WIDTH-1.
  - Requests at the current floor while moving are ignored until the next stop evaluation.
  - Simultaneous requests above and below are resolved by `dir_up`.

## Timing
- All outputs are registered, driven from state and current-floor registers.
- IDLE → DOOR_OPEN or MOVE_*: 1 cycle after the request is visible.
- Travel per floor: exactly FLOOR_TICKS cycles in MOVE_*; `current_floor` updates on the same edge as the stop decision.
- Door dwell: exactly DOOR_TICKS cycles with `door_open` = 1, then 1 IDLE cycle minimum before the next movement.
- Inactivate strobes are active from the first DOOR_OPEN cycle. The matching `active_*` bit in `buttons` drops combinationally in that same cycle.

## Configuration
- **`ELEVATOR_DOOR_HOLD_EN` defined:**
  - Adds input `door_hold`.
  - While `door_hold` = 1 in DOOR_OPEN, the door timer reloads DOOR_TICKS-1 every cycle. The door closes DOOR_TICKS cycles after `door_hold` falls.
  - `door_hold` is ignored in other states.
- **Undefined:** the port is absent and the door dwell is fixed at DOOR_TICKS.

## Structure
- **Package `elevator_pkg`:**
  - state enum (IDLE, MOVE_UP, MOVE_DOWN, DOOR_OPEN);
  - FLOOR_W computation function;
  - one-hot-from-index helper.
- **Sub-module `request_scan`:** combinational; produces `above`, `below` and `here` from the three request vectors and a floor index. It is instantiated twice: current floor for IDLE, next floor for the stop test.

## Test plan
(All with BUTTONS_WIDTH=8, FLOOR_TICKS=4, DOOR_TICKS=3.)
- **Reset:** assert `reset` mid-MOVE_UP at floor 3 → same cycle, `current_floor` = 0, IDLE, all outputs 0, `dir_up` = 1.
- **Single car request:** from idle at 0, `in[2]` = 1 → MOVE_UP for 8 cycles, `current_floor` = 2, `door_open` for 3 cycles, `inactivate_in_levels` = 8'b0000_0100 during the door phase, then IDLE.
- **Hall-call direction:** car at 0, `down[3]` and `up[5]` set → passes floor 3 without stopping, stops at 5. Then, with nothing above, reverses and stops at 3 with `inactivate_out_down_levels` = 8'b0000_1000.
- **Simultaneous above and below:** car at 4 with `dir_up` = 0, `in[6]` and `in[1]` set together → serves floor 1 first, then floor 6.
- **Request at current floor:** `up[0]` pressed while IDLE at floor 0 → DOOR_OPEN next cycle, `inactivate_out_up_levels[0]` = 1, no motor activity.
- **`ELEVATOR_DOOR_HOLD_EN`:** `door_hold` held for 10 cycles in DOOR_OPEN → door stays open for 10 + 3 cycles, then closes.
